parallel_to_serial: RTL and testbench



---
 rtl/parallel_to_serial_pkg.sv | 12 +
 rtl/parallel_to_serial_hold.sv | 28 ++
 rtl/parallel_to_serial.sv | 137 +++++++++++++
 tb/tb_parallel_to_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared types for the word-to-bit serializer.
// Latency: n/a (types only). Backpressure: n/a.
// State encoding mirrors the (busy, hold_full) pair used by parallel_to_serial.
package parallel_to_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT      = 2'd1,
        ST_SHIFT_HELD = 2'd2
    } state_t;

endpackage

// File: rtl/parallel_to_serial_hold.sv
// One-entry word holding register with full flag.
// Latency: 1 cycle write-to-full. Backpressure: owner must not write while full.
// A write takes priority over a read in the same cycle.
module parallel_to_serial_hold #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            full    <= 1'b0;
        end else if (wr_en) begin
            rd_data <= wr_data;
            full    <= 1'b1;
        end else if (rd_en) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer, LSB first (MSB first with PARALLEL_TO_SERIAL_MSB_FIRST_EN).
// Latency: first bit 1 cycle after word accept. Backpressure: serial_ready stalls shift;
// a second word parks in the hold register, parallel_ready drops while it is full.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [width-1:0] parallel_data,
    output logic             serial_valid,
    input  logic             serial_ready,
    output logic             serial_data
);

    localparam int cnt_w = $clog2(width);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(width - 1);

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] sh;
    logic [width-1:0] sh_shifted;
    logic [cnt_w-1:0] cnt;
    logic [width-1:0] hold_data;
    logic             hold_full;
    logic             busy;
    logic             p_acc;
    logic             s_acc;
    logic             last;
    logic             load_in;
    logic             load_hold;
    logic             hold_wr;
    logic             do_shift;

    assign busy  = (state != ST_IDLE);
    assign p_acc = parallel_valid & parallel_ready;
    assign s_acc = busy & serial_ready;
    assign last  = s_acc && (cnt == cnt_last);

`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
    assign sh_shifted = {sh[width-2:0], 1'b0};
`else
    assign sh_shifted = {1'b0, sh[width-1:1]};
`endif

    parallel_to_serial_hold #(
        .width (width)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hold_wr),
        .rd_en   (load_hold),
        .wr_data (parallel_data),
        .rd_data (hold_data),
        .full    (hold_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A word arriving on the last bit goes straight into sh so streams stay gapless.
    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_hold = 1'b0;
        hold_wr   = 1'b0;
        do_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (p_acc) begin
                    load_in   = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    if (p_acc) begin
                        load_in = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    do_shift = s_acc;
                    if (p_acc) begin
                        hold_wr   = 1'b1;
                        state_nxt = ST_SHIFT_HELD;
                    end
                end
            end
            ST_SHIFT_HELD: begin
                if (last) begin
                    load_hold = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    do_shift = s_acc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load_in) begin
            sh  <= parallel_data;
            cnt <= '0;
        end else if (load_hold) begin
            sh  <= hold_data;
            cnt <= '0;
        end else if (do_shift) begin
            sh  <= sh_shifted;
            cnt <= cnt + cnt_w'(1);
        end
    end

    // Every output is a direct register tap, so parallel_ready never sees serial_ready.
    always_comb begin
        serial_valid   = busy;
        parallel_ready = !hold_full;
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
        serial_data    = sh[width-1];
`else
        serial_data    = sh[0];
`endif
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: stimulus pushes expected bits/words,
// a negedge monitor compares the serial stream and reassembles words.
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       parallel_valid = 1'b0;
    logic       parallel_ready;
    logic [7:0] parallel_data = 8'h00;
    logic       serial_valid;
    logic       serial_ready = 1'b1;
    logic       serial_data;

    int checks = 0;
    int errors = 0;

    logic       exp_q[$];
    logic [7:0] word_q[$];
    logic [7:0] acc = 8'h00;
    int         nbits = 0;
    int         cur_run = 0;
    int         last_run = 0;
    int         ready_low = 0;

    parallel_to_serial #(.width(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (parallel_valid),
        .parallel_ready (parallel_ready),
        .parallel_data  (parallel_data),
        .serial_valid   (serial_valid),
        .serial_ready   (serial_ready),
        .serial_data    (serial_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Presents a word and returns 1ns after the accepting posedge; valid stays high.
    task automatic send(input logic [7:0] d);
        bit done;
        done = 1'b0;
        parallel_valid = 1'b1;
        parallel_data  = d;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (parallel_ready) begin
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
                for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
`else
                for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`endif
                word_q.push_back(d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted within 100 cycles", d);
        end
    endtask

    task automatic idle_in();
        parallel_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            acc   = 8'h00;
            nbits = 0;
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end else begin
            if (!parallel_ready) ready_low++;
            if (serial_valid) begin
                cur_run++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: serial_valid=1 data=%0b with empty scoreboard", serial_data);
                end else if (serial_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL serial_bit: got %0b expected %0b", serial_data, exp_q[0]);
                end
                if (serial_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
                    acc = {acc[6:0], serial_data};
`else
                    acc = {serial_data, acc[7:1]};
`endif
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        checks++;
                        if (word_q.size() == 0 || acc !== word_q[0]) begin
                            errors++;
                            $display("FAIL word_reassembly: got %h expected %h", acc,
                                     (word_q.size() == 0) ? 8'hxx : word_q[0]);
                        end
                        if (word_q.size() != 0) void'(word_q.pop_front());
                    end
                end
            end else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
        end
    end

    initial begin
        // Reset state before any clock edge
        #1;
        check("reset_serial_valid", int'(serial_valid), 0);
        check("reset_serial_data", int'(serial_data), 0);
        check("reset_parallel_ready", int'(parallel_ready), 1);
        #10;
        rst = 1'b1;
        wait_cycles(3);
        check("idle_serial_valid", int'(serial_valid), 0);

        // Single word, latency and length
        last_run = 0;
        send(8'hA5);
        idle_in();
        check("latency_first_bit", int'(serial_valid), 1);
        check("first_bit_value", int'(serial_data), 1);
        wait_cycles(12);
        check("single_word_run", last_run, 8);

        // Back-to-back words, gapless
        last_run  = 0;
        ready_low = 0;
        send(8'h01);
        send(8'hFF);
        check("hold_full_ready_low", int'(parallel_ready), 0);
        send(8'h3C);
        idle_in();
        wait_cycles(30);
        check("b2b_contiguous_run", last_run, 24);
        check("b2b_ready_low_cycles", ready_low, 14);

        // Backpressure mid-word with a second word held
        last_run = 0;
        send(8'h5A);
        idle_in();
        wait_cycles(2);
        serial_ready = 1'b0;
        send(8'hC3);
        idle_in();
        check("stall_ready_low", int'(parallel_ready), 0);
        check("stall_valid_held", int'(serial_valid), 1);
        wait_cycles(2);
        serial_ready = 1'b1;
        wait_cycles(25);
        check("stall_run_length", last_run, 19);

        // Reset mid-word
        send(8'hF0);
        idle_in();
        wait_cycles(3);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_serial_valid", int'(serial_valid), 0);
        check("midrst_serial_data", int'(serial_data), 0);
        check("midrst_parallel_ready", int'(parallel_ready), 1);
        exp_q.delete();
        word_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        wait_cycles(2);
        last_run = 0;
        send(8'h0F);
        idle_in();
        wait_cycles(12);
        check("after_reset_run", last_run, 8);

        // Single-bit-set word: first bit depends on build order
        send(8'h80);
        idle_in();
`ifdef PARALLEL_TO_SERIAL_MSB_FIRST_EN
        check("w80_first_bit", int'(serial_data), 1);
`else
        check("w80_first_bit", int'(serial_data), 0);
`endif
        wait_cycles(12);

        check("scoreboard_bits_drained", exp_q.size(), 0);
        check("scoreboard_words_drained", word_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
